// File: rtl/trap_sequencer_if.sv
// Bundle of commit-stage request, CSR file and redirect signals seen by
// trap_sequencer. The master side is the pipeline/CSR environment; the
// slave side is the sequencer itself.
interface trap_sequencer_if #(
  parameter int unsigned XLEN = 64
);
  // commit-stage request
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_pc;
  logic            req_ecall;
  logic            req_mret;
  logic            irq_pending;
  // CSR file access
  logic            csr_ren;
  logic [11:0]     csr_raddr;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_wen1;
  logic [11:0]     csr_waddr1;
  logic [XLEN-1:0] csr_wdata1;
  logic            csr_wen2;
  logic [11:0]     csr_waddr2;
  logic [XLEN-1:0] csr_wdata2;
  logic            csr_ecall;
  logic            csr_mret;
  logic            handle_timer_intr;
  // pipeline control
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            stall;
  logic [31:0]     trap_count;

  modport master (
    output req_valid, req_pc, req_ecall, req_mret, irq_pending, csr_rdata,
    input  req_ready, csr_ren, csr_raddr,
    input  csr_wen1, csr_waddr1, csr_wdata1,
    input  csr_wen2, csr_waddr2, csr_wdata2,
    input  csr_ecall, csr_mret, handle_timer_intr,
    input  redirect_valid, redirect_pc, stall, trap_count
  );

  modport slave (
    input  req_valid, req_pc, req_ecall, req_mret, irq_pending, csr_rdata,
    output req_ready, csr_ren, csr_raddr,
    output csr_wen1, csr_waddr1, csr_wdata1,
    output csr_wen2, csr_waddr2, csr_wdata2,
    output csr_ecall, csr_mret, handle_timer_intr,
    output redirect_valid, redirect_pc, stall, trap_count
  );
endinterface

// File: rtl/trap_sequencer.sv
// trap_sequencer: sequences ecall / timer-interrupt trap entry and mret
// return against a dual-write-port machine-mode CSR file, stalling the
// pipeline for the whole sequence and finishing with a PC redirect.
// Optional macro TRAP_VECTORED_EN: vectored mtvec mode (mode bits 01)
// offsets the interrupt target by 4*TIMER_CAUSE.
module trap_sequencer #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned ECALL_CAUSE = 11,
  parameter int unsigned TIMER_CAUSE = 7
) (
  input  logic               clock,
  input  logic               reset,
  trap_sequencer_if.slave    bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD_VEC = 3'd1;
  localparam logic [2:0] S_WR_CSR = 3'd2;
  localparam logic [2:0] S_RD_EPC = 3'd3;
  localparam logic [2:0] S_REDIR  = 3'd4;

  localparam logic [1:0] K_INT   = 2'd0;
  localparam logic [1:0] K_ECALL = 2'd1;
  localparam logic [1:0] K_MRET  = 2'd2;

  localparam logic [11:0] A_MTVEC  = 12'h305;
  localparam logic [11:0] A_MEPC   = 12'h341;
  localparam logic [11:0] A_MCAUSE = 12'h342;

  logic [2:0]      r_state;
  logic [1:0]      r_kind;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_vec;
  logic [XLEN-1:0] r_epc;
  logic [31:0]     r_trap_count;

  logic            w_accept;
  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_trap_target;
  logic [XLEN-1:0] w_cause;

  assign w_accept = bus.req_valid && (r_state == S_IDLE) &&
                    (bus.irq_pending || bus.req_ecall || bus.req_mret);

  assign w_base  = r_vec & ~XLEN'(3);
  assign w_cause = (r_kind == K_INT) ? {1'b1, (XLEN-1)'(TIMER_CAUSE)}
                                     : XLEN'(ECALL_CAUSE);

`ifdef TRAP_VECTORED_EN
  assign w_trap_target = ((r_kind == K_INT) && (r_vec[1:0] == 2'b01))
                         ? w_base + XLEN'(4 * TIMER_CAUSE) : w_base;
`else
  assign w_trap_target = w_base;
`endif

  // state machine plus latched request kind, pc and CSR read results
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_kind  <= K_INT;
      r_pc    <= '0;
      r_vec   <= '0;
      r_epc   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_pc <= bus.req_pc;
            if (bus.irq_pending) begin
              r_kind  <= K_INT;
              r_state <= S_RD_VEC;
            end else if (bus.req_ecall) begin
              r_kind  <= K_ECALL;
              r_state <= S_RD_VEC;
            end else begin
              r_kind  <= K_MRET;
              r_state <= S_RD_EPC;
            end
          end
        end
        S_RD_VEC: begin
          r_vec   <= bus.csr_rdata;
          r_state <= S_WR_CSR;
        end
        S_WR_CSR: r_state <= S_REDIR;
        S_RD_EPC: begin
          r_epc   <= bus.csr_rdata;
          r_state <= S_REDIR;
        end
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // trap entries counted on leaving WR_CSR so the count is visible during REDIR
  always_ff @(posedge clock) begin
    if (reset) r_trap_count <= '0;
    else       r_trap_count <= r_trap_count + 32'(r_state == S_WR_CSR);
  end

  // output decode; reset forces every output to its idle value in the same cycle
  always_comb begin
    bus.req_ready         = 1'b0;
    bus.stall             = 1'b0;
    bus.csr_ren           = 1'b0;
    bus.csr_raddr         = '0;
    bus.csr_wen1          = 1'b0;
    bus.csr_waddr1        = '0;
    bus.csr_wdata1        = '0;
    bus.csr_wen2          = 1'b0;
    bus.csr_waddr2        = '0;
    bus.csr_wdata2        = '0;
    bus.csr_ecall         = 1'b0;
    bus.csr_mret          = 1'b0;
    bus.handle_timer_intr = 1'b0;
    bus.redirect_valid    = 1'b0;
    bus.redirect_pc       = '0;
    bus.trap_count        = '0;
    if (!reset) begin
      bus.trap_count = r_trap_count;
      bus.req_ready  = (r_state == S_IDLE);
      bus.stall      = (r_state != S_IDLE);
      case (r_state)
        S_RD_VEC: begin
          bus.csr_ren   = 1'b1;
          bus.csr_raddr = A_MTVEC;
        end
        S_WR_CSR: begin
          bus.csr_wen1          = 1'b1;
          bus.csr_waddr1        = A_MEPC;
          bus.csr_wdata1        = r_pc;
          bus.csr_wen2          = 1'b1;
          bus.csr_waddr2        = A_MCAUSE;
          bus.csr_wdata2        = w_cause;
          bus.csr_ecall         = (r_kind == K_ECALL);
          bus.handle_timer_intr = (r_kind == K_INT);
        end
        S_RD_EPC: begin
          bus.csr_ren   = 1'b1;
          bus.csr_raddr = A_MEPC;
        end
        S_REDIR: begin
          bus.redirect_valid = 1'b1;
          if (r_kind == K_MRET) begin
            bus.redirect_pc = r_epc;
            bus.csr_mret    = 1'b1;
          end else begin
            bus.redirect_pc = w_trap_target;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: each accepted request is expanded
// by a transaction-level model into the list of per-cycle outputs it must
// produce; every cycle the DUT outputs are compared against that list.
module tb_trap_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  trap_sequencer_if #(.XLEN(64)) u_if ();

  trap_sequencer #(
    .XLEN       (64),
    .ECALL_CAUSE(11),
    .TIMER_CAUSE(7)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (u_if.slave)
  );

  // CSR file contents seen by the sequencer's read port
  logic [63:0] mtvec = 64'h0;
  logic [63:0] mepc  = 64'h0;
  assign u_if.csr_rdata = (u_if.csr_raddr == 12'h305) ? mtvec :
                          (u_if.csr_raddr == 12'h341) ? mepc  : 64'h0;

  typedef struct {
    logic        ready, stall, ren, wen1, wen2, ecall, mret, tintr, rv;
    logic [11:0] raddr, waddr1, waddr2;
    logic [63:0] wdata1, wdata2, rpc;
    logic [31:0] count;
  } rec_t;

  rec_t        exp_q[$];
  logic [31:0] m_count = 0;
  int unsigned n_err = 0;
  int unsigned n_chk = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic rec_t blank(input logic [31:0] cnt);
    rec_t r;
    r.ready = 0; r.stall = 0; r.ren = 0; r.wen1 = 0; r.wen2 = 0;
    r.ecall = 0; r.mret = 0; r.tintr = 0; r.rv = 0;
    r.raddr = 0; r.waddr1 = 0; r.waddr2 = 0;
    r.wdata1 = 0; r.wdata2 = 0; r.rpc = 0; r.count = cnt;
    return r;
  endfunction

  // expand one accepted request into its expected per-cycle outputs
  task automatic push_seq();
    rec_t r;
    logic is_int, is_ecall;
    logic [63:0] target;
    is_int   = u_if.irq_pending;
    is_ecall = !is_int && u_if.req_ecall;
    if (is_int || is_ecall) begin
      target = mtvec & ~64'd3;
`ifdef TRAP_VECTORED_EN
      if (is_int && mtvec[1:0] == 2'b01) target = target + 64'd28;
`endif
      r = blank(m_count); r.stall = 1; r.ren = 1; r.raddr = 12'h305;
      exp_q.push_back(r);
      r = blank(m_count); r.stall = 1;
      r.wen1 = 1; r.waddr1 = 12'h341; r.wdata1 = u_if.req_pc;
      r.wen2 = 1; r.waddr2 = 12'h342;
      r.wdata2 = is_int ? 64'h8000_0000_0000_0007 : 64'd11;
      r.ecall = is_ecall; r.tintr = is_int;
      exp_q.push_back(r);
      m_count = m_count + 1;
      r = blank(m_count); r.stall = 1; r.rv = 1; r.rpc = target;
      exp_q.push_back(r);
    end else begin
      r = blank(m_count); r.stall = 1; r.ren = 1; r.raddr = 12'h341;
      exp_q.push_back(r);
      r = blank(m_count); r.stall = 1; r.rv = 1; r.rpc = mepc; r.mret = 1;
      exp_q.push_back(r);
    end
  endtask

  // compare one cycle of outputs and advance the model across the clock edge
  task automatic run_cycle();
    rec_t e;
    @(negedge clock);
    if (reset)                 e = blank(32'd0);
    else if (exp_q.size() > 0) e = exp_q[0];
    else begin                 e = blank(m_count); e.ready = 1; end
    chk("req_ready",  64'(u_if.req_ready),         64'(e.ready));
    chk("stall",      64'(u_if.stall),             64'(e.stall));
    chk("csr_ren",    64'(u_if.csr_ren),           64'(e.ren));
    chk("csr_raddr",  64'(u_if.csr_raddr),         64'(e.raddr));
    chk("csr_wen1",   64'(u_if.csr_wen1),          64'(e.wen1));
    chk("csr_waddr1", 64'(u_if.csr_waddr1),        64'(e.waddr1));
    chk("csr_wdata1", u_if.csr_wdata1,             e.wdata1);
    chk("csr_wen2",   64'(u_if.csr_wen2),          64'(e.wen2));
    chk("csr_waddr2", 64'(u_if.csr_waddr2),        64'(e.waddr2));
    chk("csr_wdata2", u_if.csr_wdata2,             e.wdata2);
    chk("csr_ecall",  64'(u_if.csr_ecall),         64'(e.ecall));
    chk("csr_mret",   64'(u_if.csr_mret),          64'(e.mret));
    chk("timer_intr", 64'(u_if.handle_timer_intr), 64'(e.tintr));
    chk("redir_v",    64'(u_if.redirect_valid),    64'(e.rv));
    chk("redir_pc",   u_if.redirect_pc,            e.rpc);
    chk("trap_count", 64'(u_if.trap_count),        64'(e.count));
    if (reset) begin
      exp_q.delete();
      m_count = 0;
    end else if (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
    end else if (u_if.req_valid && (u_if.irq_pending || u_if.req_ecall || u_if.req_mret)) begin
      push_seq();
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] pc, input logic ec,
                       input logic mr, input logic irq);
    u_if.req_valid   = v;
    u_if.req_pc      = pc;
    u_if.req_ecall   = ec;
    u_if.req_mret    = mr;
    u_if.irq_pending = irq;
  endtask

  task automatic idle_cycles(input int unsigned n);
    drive(0, 64'h0, 0, 0, 0);
    for (int unsigned i = 0; i < n; i++) run_cycle();
  endtask

  initial begin
    drive(0, 64'h0, 0, 0, 0);
    reset = 1;
    run_cycle();
    run_cycle();
    reset = 0;
    idle_cycles(2);

    // ecall to a direct-mode mtvec
    mtvec = 64'h8000_1000;
    drive(1, 64'h8000_0010, 1, 0, 0); run_cycle();
    idle_cycles(5);

    // interrupt beats a simultaneous ecall
    drive(1, 64'h8000_0020, 1, 0, 1); run_cycle();
    idle_cycles(5);

    // mret
    mepc = 64'h8000_0014;
    drive(1, 64'h8000_0030, 0, 1, 0); run_cycle();
    idle_cycles(4);

    // vectored-mode mtvec: interrupt, then ecall
    mtvec = 64'h8000_1001;
    drive(1, 64'h8000_0040, 0, 0, 1); run_cycle();
    idle_cycles(5);
    drive(1, 64'h8000_0044, 1, 0, 0); run_cycle();
    idle_cycles(5);

    // request with no cause is ignored
    drive(1, 64'h8000_0050, 0, 0, 0); run_cycle(); run_cycle();

    // reset landing on WR_CSR
    drive(1, 64'h8000_0060, 1, 0, 0); run_cycle();
    drive(0, 64'h0, 0, 0, 0); run_cycle();
    reset = 1; run_cycle();
    reset = 0; idle_cycles(2);

    // back-to-back ecalls with req_valid held high
    mtvec = 64'h8000_2000;
    drive(1, 64'h8000_0070, 1, 0, 0);
    for (int unsigned i = 0; i < 9; i++) run_cycle();
    idle_cycles(4);

    // trap_count wrap from all-ones
    force dut.r_trap_count = 32'hFFFF_FFFF;
    m_count = 32'hFFFF_FFFF;
    run_cycle();
    release dut.r_trap_count;
    run_cycle();
    drive(1, 64'h8000_0080, 1, 0, 0); run_cycle();
    idle_cycles(5);

    // randomized traffic
    for (int unsigned i = 0; i < 600; i++) begin
      if (exp_q.size() == 0) begin
        mtvec = {$urandom, $urandom};
        mepc  = {$urandom, $urandom};
      end
      drive($urandom_range(0, 1) == 1, {$urandom, $urandom},
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 63) == 0);
      run_cycle();
    end
    reset = 0;
    idle_cycles(5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
